s5s_dpr_rsp: RTL and testbench



---
 rtl/s5s_dpr_pkg.sv | 22 ++
 rtl/s5s_dpr_lat_cnt.sv | 36 +++
 rtl/s5s_dpr_rsp.sv | 108 ++++++++++
 tb/tb_s5s_dpr_rsp.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/s5s_dpr_pkg.sv
// Shared types for the s5s DPR responder: command encoding, FSM states and
// the latency-counter width helper.
package s5s_dpr_pkg;

    typedef enum logic [1:0] {
        NOP = 2'b00,
        INC = 2'b01,
        DEC = 2'b10,
        CLR = 2'b11
    } t_dpr_cmd;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } t_dpr_rsp_state;

    // A LATENCY of 1 still needs a 1-bit counter so the port widths stay legal.
    function automatic int lat_cnt_w(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/s5s_dpr_lat_cnt.sv
// Loadable down-counter that saturates at zero; hold freezes it, load wins over hold.
// Zero flag is decoded from the count register only.
module s5s_dpr_lat_cnt #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         hold_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (!hold_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/s5s_dpr_rsp.sv
// DPR responder: one req/cmd accepted in IDLE, rdy pulses LATENCY(+stall) cycles later,
// command executes on the edge closing the rdy cycle; BUSY-time req/cmd changes set sticky err.
module s5s_dpr_rsp
    import s5s_dpr_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [1:0]        cmd,
    input  logic              stall,
    output logic              rdy,
    output logic [DATA_W-1:0] value,
    output logic              wrap,
    output logic              err
);

    localparam int CNT_W = lat_cnt_w(LATENCY);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    if (LATENCY < 1) begin : g_bad_latency
        $error("s5s_dpr_rsp: LATENCY must be >= 1");
    end

    t_dpr_rsp_state    state_q;
    t_dpr_cmd          cmd_q;
    logic [DATA_W-1:0] value_q;
    logic              wrap_q;
    logic              err_q;

    logic              cnt_zero;
    logic              busy;
    logic              cnt_load;
    logic [DATA_W-1:0] value_d;
    logic              wrap_d;

    assign busy     = (state_q == BUSY);
    assign cnt_load = (state_q == IDLE) && req;

    s5s_dpr_lat_cnt #(
        .W (CNT_W)
    ) u_lat_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (LOAD_VAL),
        .hold_i     (stall),
        .zero_o     (cnt_zero)
    );

    // Result of executing the captured command; only committed on the rdy cycle.
    always_comb begin
        value_d = value_q;
        wrap_d  = wrap_q;
        unique case (cmd_q)
            NOP: ;
            INC: begin
                value_d = value_q + DATA_W'(1);
                if (value_q == '1) wrap_d = 1'b1;
            end
            DEC: begin
                value_d = value_q - DATA_W'(1);
                if (value_q == '0) wrap_d = 1'b1;
            end
            CLR: begin
                value_d = '0;
                wrap_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= NOP;
            value_q <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (busy && (req || (cmd != cmd_q))) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        cmd_q   <= t_dpr_cmd'(cmd);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_zero) begin
                        value_q <= value_d;
                        wrap_q  <= wrap_d;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign rdy   = busy && cnt_zero;
    assign value = value_q;
    assign wrap  = wrap_q;
    assign err   = err_q;

endmodule

// File: tb/tb_s5s_dpr_rsp.sv
// Directed bench for s5s_dpr_rsp: four instances with LATENCY 1..4 share clock and reset.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_s5s_dpr_rsp;
    import s5s_dpr_pkg::*;

    logic       clk;
    logic       rst;
    logic       dut_req   [4];
    logic [1:0] dut_cmd   [4];
    logic       dut_stall [4];
    logic       dut_rdy   [4];
    logic [7:0] dut_value [4];
    logic       dut_wrap  [4];
    logic       dut_err   [4];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance g has LATENCY g+1.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        s5s_dpr_rsp #(
            .DATA_W  (8),
            .LATENCY (g + 1)
        ) u_dut (
            .clk   (clk),
            .rst   (rst),
            .req   (dut_req[g]),
            .cmd   (dut_cmd[g]),
            .stall (dut_stall[g]),
            .rdy   (dut_rdy[g]),
            .value (dut_value[g]),
            .wrap  (dut_wrap[g]),
            .err   (dut_err[g])
        );
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command on instance i, measure cycles until rdy, step past rdy.
    task automatic issue(input int i, input logic [1:0] c, input int exp_lat);
        int lat;
        lat = 0;
        dut_req[i] = 1'b1;
        dut_cmd[i] = c;
        tick();
        dut_req[i] = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (dut_rdy[i]) begin
                lat = n;
                break;
            end
            tick();
        end
        tick();
        check_val("issue_latency", lat, exp_lat);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dut_req[i]   = 1'b0;
            dut_cmd[i]   = 2'b00;
            dut_stall[i] = 1'b0;
        end
        repeat (3) tick();
        rst = 1'b0;

        // Reset state on every instance.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check_val("reset_rdy", dut_rdy[i], 0);
            check_val("reset_value", dut_value[i], 0);
            check_val("reset_wrap", dut_wrap[i], 0);
            check_val("reset_err", dut_err[i], 0);
        end
        tick();

        // LATENCY=2: INC at cycle 5, rdy only at 7, value=1 from 8.
        for (int c = 0; c < 10; c++) begin
            dut_req[1] = (c == 5);
            dut_cmd[1] = INC;
            @(negedge clk);
            check_val("l2_rdy", dut_rdy[1], (c == 7));
            check_val("l2_value", dut_value[1], (c >= 8) ? 1 : 0);
            tick();
        end
        check_val("l2_err", dut_err[1], 0);

        // LATENCY=4 with stall in cycles 1-2: rdy at 6.
        for (int c = 0; c < 9; c++) begin
            dut_req[3]   = (c == 0);
            dut_cmd[3]   = INC;
            dut_stall[3] = (c == 1) || (c == 2);
            @(negedge clk);
            check_val("l4_stall_rdy", dut_rdy[3], (c == 6));
            tick();
        end
        check_val("l4_stall_value", dut_value[3], 1);
        check_val("l4_stall_err", dut_err[3], 0);

        // LATENCY=1 with stall held high: rdy at 1 regardless.
        for (int c = 0; c < 4; c++) begin
            dut_req[0]   = (c == 0);
            dut_cmd[0]   = INC;
            dut_stall[0] = 1'b1;
            @(negedge clk);
            check_val("l1_stall_rdy", dut_rdy[0], (c == 1));
            tick();
        end
        dut_stall[0] = 1'b0;
        check_val("l1_stall_value", dut_value[0], 1);

        // Wrap and clear on LATENCY=2 instance (value currently 1).
        issue(1, CLR, 2);
        check_val("clr_value", dut_value[1], 0);
        issue(1, DEC, 2);
        check_val("dec_wrap_value", dut_value[1], 255);
        check_val("dec_wrap_flag", dut_wrap[1], 1);
        issue(1, INC, 2);
        check_val("inc_wrap_value", dut_value[1], 0);
        check_val("inc_wrap_flag", dut_wrap[1], 1);
        issue(1, CLR, 2);
        check_val("clr2_value", dut_value[1], 0);
        check_val("clr2_wrap", dut_wrap[1], 0);

        // Back-to-back on LATENCY=1: req 0,2,4 -> rdy 1,3,5.
        issue(0, CLR, 1);
        for (int c = 0; c < 7; c++) begin
            dut_req[0] = (c == 0) || (c == 2) || (c == 4);
            dut_cmd[0] = INC;
            @(negedge clk);
            check_val("b2b_rdy", dut_rdy[0], (c == 1) || (c == 3) || (c == 5));
            tick();
        end
        check_val("b2b_value", dut_value[0], 3);
        check_val("b2b_err", dut_err[0], 0);

        // LATENCY=3: second req in BUSY cycle 1 is dropped and flagged.
        for (int c = 0; c < 7; c++) begin
            dut_req[2] = (c == 0) || (c == 1);
            dut_cmd[2] = INC;
            @(negedge clk);
            check_val("viol_req_rdy", dut_rdy[2], (c == 3));
            check_val("viol_req_err", dut_err[2], (c >= 2));
            check_val("viol_req_value", dut_value[2], (c >= 4) ? 1 : 0);
            tick();
        end

        // LATENCY=4: cmd changes to DEC in BUSY cycle 2; INC still executes.
        for (int c = 0; c < 7; c++) begin
            dut_req[3] = (c == 0);
            dut_cmd[3] = (c == 2) ? DEC : INC;
            @(negedge clk);
            check_val("viol_cmd_rdy", dut_rdy[3], (c == 4));
            check_val("viol_cmd_err", dut_err[3], (c >= 3));
            tick();
        end
        check_val("viol_cmd_value", dut_value[3], 2);

        // Reset in cycle 1 of a LATENCY=3 INC aborts it.
        for (int c = 0; c < 7; c++) begin
            rst        = (c == 1);
            dut_req[2] = (c == 0);
            dut_cmd[2] = INC;
            @(negedge clk);
            check_val("rst_mid_rdy", dut_rdy[2], 0);
            check_val("rst_mid_value", dut_value[2], (c >= 2) ? 0 : 1);
            if (c >= 2) check_val("rst_mid_err", dut_err[2], 0);
            tick();
        end
        check_val("rst_other_value", dut_value[3], 0);
        check_val("rst_other_err", dut_err[3], 0);
        issue(2, INC, 3);
        check_val("post_rst_value", dut_value[2], 1);
        check_val("post_rst_err", dut_err[2], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
